// File: rtl/alu_logic_issuer_pkg.sv
// Shared definitions for the logic-op issuer: opcodes, FSM encoding, request layout.
package alu_logic_issuer_pkg;

  localparam int DATA_W = 8;
  localparam int SEL_W  = 4;
  localparam int REQ_W  = SEL_W + 2 * DATA_W;

  localparam logic [SEL_W-1:0] OP_NOTA = 4'd8;
  localparam logic [SEL_W-1:0] OP_NOTB = 4'd9;
  localparam logic [SEL_W-1:0] OP_AND  = 4'd10;
  localparam logic [SEL_W-1:0] OP_OR   = 4'd11;
  localparam logic [SEL_W-1:0] OP_NAND = 4'd12;
  localparam logic [SEL_W-1:0] OP_NOR  = 4'd13;
  localparam logic [SEL_W-1:0] OP_XOR  = 4'd14;
  localparam logic [SEL_W-1:0] OP_XNOR = 4'd15;

  localparam logic [SEL_W-1:0] OP_LEGAL_MIN = OP_NOTA;
  localparam logic [SEL_W-1:0] OP_LEGAL_MAX = OP_XNOR;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DRIVE   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_HOLD    = 2'd3;

  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } req_t;

  // The upper bound equals the field maximum, so only the lower bound needs testing.
  function automatic logic op_is_legal(input logic [SEL_W-1:0] sel);
    return sel >= OP_LEGAL_MIN;
  endfunction

endpackage

// File: rtl/alu_logic_issuer_sync_fifo.sv
// Single-clock FIFO with extra-bit pointers; push when full / pop when empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset: an entry is only ever read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/alu_logic_issuer.sv
// Queues logic-op requests, drives a registered downstream logic unit and returns results in order.
module alu_logic_issuer
  import alu_logic_issuer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [SEL_W-1:0]  in_sel,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_c,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_c,
  output logic [SEL_W-1:0]  out_sel,
  output logic              out_err,
  output logic [7:0]        op_count,
  output logic [7:0]        err_count
);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [SEL_W-1:0]  alu_sel_q, alu_sel_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_c_q, out_c_d;
  logic [SEL_W-1:0]  out_sel_q, out_sel_d;
  logic              out_err_q, out_err_d;
  logic [7:0]        op_count_q, op_count_d, err_count_q, err_count_d;

  logic              fifo_full, fifo_empty, fifo_pop, fifo_push, issue;
  req_t              fifo_din, head;

  // in_ready ignores any same-cycle pop and is held low while reset is asserted.
  assign in_ready  = !fifo_full && !rst;
  assign fifo_push = in_valid && in_ready;
  assign fifo_din  = '{sel: in_sel, a: in_a, b: in_b};

  sync_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    out_valid_d = out_valid_q;
    out_c_d     = out_c_q;
    out_sel_d   = out_sel_q;
    out_err_d   = out_err_q;
    op_count_d  = op_count_q;
    err_count_d = err_count_q;
    fifo_pop    = 1'b0;
    issue       = 1'b0;

    case (state_q)
      ST_IDLE:  issue = 1'b1;
      ST_DRIVE: state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        out_c_d     = alu_c;
        out_sel_d   = alu_sel_q;
        out_err_d   = 1'b0;
        out_valid_d = 1'b1;
        op_count_d  = op_count_q + 8'd1;
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          issue       = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Shared issue decision for IDLE and a completed HOLD handshake (no bubble between ops).
    if (issue) begin
      state_d = ST_IDLE;
      if (!fifo_empty) begin
        fifo_pop = 1'b1;
        if (op_is_legal(head.sel)) begin
          alu_a_d   = head.a;
          alu_b_d   = head.b;
          alu_sel_d = head.sel;
          state_d   = ST_DRIVE;
        end else begin
          out_c_d     = '0;
          out_sel_d   = head.sel;
          out_err_d   = 1'b1;
          out_valid_d = 1'b1;
          err_count_d = err_count_q + 8'd1;
          state_d     = ST_HOLD;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= OP_AND;
      out_valid_q <= 1'b0;
      out_c_q     <= '0;
      out_sel_q   <= '0;
      out_err_q   <= 1'b0;
      op_count_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      out_valid_q <= out_valid_d;
      out_c_q     <= out_c_d;
      out_sel_q   <= out_sel_d;
      out_err_q   <= out_err_d;
      op_count_q  <= op_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign out_valid = out_valid_q;
  assign out_c     = out_c_q;
  assign out_sel   = out_sel_q;
  assign out_err   = out_err_q;
  assign op_count  = op_count_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_alu_logic_issuer.sv
// Bench for alu_logic_issuer: registered logic unit model plus an in-order result scoreboard.
module tb_alu_logic_issuer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a, in_b;
  logic [3:0] in_sel;
  logic [7:0] alu_a, alu_b, alu_c;
  logic [3:0] alu_sel;
  logic       out_valid, out_ready;
  logic [7:0] out_c;
  logic [3:0] out_sel;
  logic       out_err;
  logic [7:0] op_count, err_count;

  typedef struct packed {
    logic [7:0] c;
    logic [3:0] sel;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_logic_issuer #(.FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sel    (in_sel),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_c     (alu_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_c     (out_c),
    .out_sel   (out_sel),
    .out_err   (out_err),
    .op_count  (op_count),
    .err_count (err_count)
  );

  function automatic logic [7:0] lu_eval(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] sel);
    case (sel)
      4'd8:    return ~a;
      4'd9:    return ~b;
      4'd10:   return a & b;
      4'd11:   return a | b;
      4'd12:   return ~(a & b);
      4'd13:   return ~(a | b);
      4'd14:   return a ^ b;
      4'd15:   return ~(a ^ b);
      default: return 8'h00;
    endcase
  endfunction

  // Downstream logic unit: result registered one clock after its inputs.
  always_ff @(posedge clk) alu_c <= lu_eval(alu_a, alu_b, alu_sel);

  // Scoreboard: record accepted requests, compare every completed result in order.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL sb_unexpected: got c=%02h sel=%0d err=%0b, no result expected",
                   out_c, out_sel, out_err);
        end else begin
          e = sb.pop_front();
          if ({out_c, out_sel, out_err} !== e) begin
            miscompares++;
            $display("FAIL sb_result: got c=%02h sel=%0d err=%0b, expected c=%02h sel=%0d err=%0b",
                     out_c, out_sel, out_err, e.c, e.sel, e.err);
          end
        end
      end
      if (in_valid && in_ready) begin
        if (in_sel >= 4'd8) sb.push_back('{c: lu_eval(in_a, in_b, in_sel), sel: in_sel, err: 1'b0});
        else                sb.push_back('{c: 8'h00, sel: in_sel, err: 1'b1});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_out_valid(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
  endtask

  task automatic push_wait(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                           output bit ok);
    bit r;
    ok = 1'b0;
    in_valid = 1'b1; in_a = a; in_b = b; in_sel = sel;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      r = in_ready;
      tick();
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sel = '0; out_ready = 1'b0;
    tick(); tick();
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++; $display("FAIL rst_in_ready: got %0b, expected 0", in_ready);
    end
    vectors++;
    if ({out_valid, out_c, out_sel, out_err, op_count, err_count, alu_a, alu_b, alu_sel} !==
        {1'b0, 8'h00, 4'd0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 4'd10}) begin
      miscompares++;
      $display("FAIL rst_outputs: got v=%0b c=%02h sel=%0d err=%0b opc=%0d errc=%0d a=%02h b=%02h asel=%0d, expected reset values",
               out_valid, out_c, out_sel, out_err, op_count, err_count, alu_a, alu_b, alu_sel);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_release: got in_ready=%0b out_valid=%0b, expected 1/0", in_ready, out_valid);
    end
    tick();
  endtask

  task automatic test_single_and();
    int acc;
    bit seen, ok;
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 8'hF0; in_b = 8'h3C; in_sel = 4'd10;
    tick();
    acc = cyc;
    in_valid = 1'b0;
    wait_out_valid(10, seen);
    vectors++;
    if (!seen || (cyc - acc) != 3) begin
      miscompares++; $display("FAIL and_latency: got seen=%0b lat=%0d, expected 3", seen, cyc - acc);
    end
    vectors++;
    if ({out_c, out_sel, out_err, op_count} !== {8'h30, 4'd10, 1'b0, 8'd1}) begin
      miscompares++;
      $display("FAIL and_result: got c=%02h sel=%0d err=%0b opc=%0d, expected 30/10/0/1",
               out_c, out_sel, out_err, op_count);
    end
    tick();
    drain(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL and_drain: got timeout, expected drained"); end
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    bit seen, ok;
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 8'h5A; in_b = 8'h00; in_sel = 4'd8;
    tick();
    in_a = 8'hFF; in_b = 8'h0F; in_sel = 4'd15;
    tick();
    in_valid = 1'b0;
    wait_out_valid(10, seen);
    t1 = cyc;
    vectors++;
    if (!seen || out_c !== 8'hA5) begin
      miscompares++; $display("FAIL b2b_first: got seen=%0b c=%02h, expected A5", seen, out_c);
    end
    tick();
    wait_out_valid(10, seen);
    t2 = cyc;
    vectors++;
    if (!seen || out_c !== 8'h0F || (t2 - t1) != 3) begin
      miscompares++;
      $display("FAIL b2b_second: got seen=%0b c=%02h gap=%0d, expected 0F gap 3", seen, out_c, t2 - t1);
    end
    tick();
    drain(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL b2b_drain: got timeout, expected drained"); end
  endtask

  task automatic test_illegal();
    int acc;
    bit seen, ok;
    logic [3:0] sel_before;
    logic [7:0] opc_before;
    sel_before = alu_sel;
    opc_before = op_count;
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 8'h11; in_b = 8'h00; in_sel = 4'd3;
    tick();
    acc = cyc;
    in_valid = 1'b0;
    wait_out_valid(10, seen);
    vectors++;
    if (!seen || (cyc - acc) != 1) begin
      miscompares++; $display("FAIL ill_latency: got seen=%0b lat=%0d, expected 1", seen, cyc - acc);
    end
    vectors++;
    if ({out_c, out_sel, out_err, err_count, op_count} !== {8'h00, 4'd3, 1'b1, 8'd1, opc_before}) begin
      miscompares++;
      $display("FAIL ill_result: got c=%02h sel=%0d err=%0b errc=%0d opc=%0d, expected 00/3/1/1/%0d",
               out_c, out_sel, out_err, err_count, op_count, opc_before);
    end
    vectors++;
    if (alu_sel !== sel_before) begin
      miscompares++; $display("FAIL ill_alu_sel: got %0d, expected %0d", alu_sel, sel_before);
    end
    tick();
    drain(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL ill_drain: got timeout, expected drained"); end
  endtask

  task automatic test_backpressure();
    bit ok, stable;
    logic [7:0] hold_c, opc_before;
    int accepted = 0;
    opc_before = op_count;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      push_wait(8'($urandom), 8'($urandom), 4'($urandom_range(15, 8)), ok);
      if (ok) accepted++;
    end
    vectors++;
    if (accepted != 5) begin
      miscompares++; $display("FAIL bp_accept: got %0d accepted, expected 5", accepted);
    end
    tick(); tick(); tick();
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_full: got in_ready=%0b out_valid=%0b, expected 0/1", in_ready, out_valid);
    end
    hold_c = out_c;
    stable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_c !== hold_c || out_valid !== 1'b1) stable = 1'b0;
    end
    vectors++;
    if (!stable) begin
      miscompares++; $display("FAIL bp_stable: got c=%02h v=%0b, expected c=%02h held", out_c, out_valid, hold_c);
    end
    tick();
    out_ready = 1'b1;
    drain(ok);
    vectors++;
    if (!ok || op_count !== opc_before + 8'd5) begin
      miscompares++;
      $display("FAIL bp_drain: got ok=%0b opc=%0d, expected drained opc=%0d", ok, op_count, opc_before + 8'd5);
    end
  endtask

  task automatic test_reset_mid();
    bit quiet;
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 8'h12; in_b = 8'h34; in_sel = 4'd11;
    tick();
    in_a = 8'h56; in_sel = 4'd14;
    tick();
    in_a = 8'h9A; in_sel = 4'd12;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    @(negedge clk);
    vectors++;
    if ({in_ready, out_valid, out_c, out_sel, out_err, op_count, err_count, alu_a, alu_b, alu_sel} !==
        {1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 4'd10}) begin
      miscompares++;
      $display("FAIL midrst_outputs: got rdy=%0b v=%0b c=%02h sel=%0d err=%0b opc=%0d errc=%0d a=%02h b=%02h asel=%0d, expected reset values",
               in_ready, out_valid, out_c, out_sel, out_err, op_count, err_count, alu_a, alu_b, alu_sel);
    end
    tick();
    rst = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || op_count !== 8'h00) quiet = 1'b0;
    end
    vectors++;
    if (!quiet || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_stale: got v=%0b opc=%0d rdy=%0b, expected 0/0/1", out_valid, op_count, in_ready);
    end
    tick();
  endtask

  task automatic test_wrap();
    bit ok;
    int accepted = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      push_wait(8'($urandom), 8'($urandom), 4'($urandom_range(15, 8)), ok);
      if (ok) accepted++;
    end
    drain(ok);
    vectors++;
    if (!ok || accepted != 256 || op_count !== 8'h00 || err_count !== 8'h00) begin
      miscompares++;
      $display("FAIL wrap: got ok=%0b accepted=%0d opc=%02h errc=%02h, expected 256 accepted opc=00 errc=00",
               ok, accepted, op_count, err_count);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_and();
    test_back_to_back();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++; $display("FAIL sb_leftover: got %0d pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
